// File: rtl/soin_bpredictor_update_ctrl.sv
// -----------------------------------------------------------------------------
// soin_bpredictor_update_ctrl
//
// Write-port controller for the bimodal predictor pattern table
// (256 x 32-bit, four byte lanes). After reset it sweeps every entry to
// {4{INIT_BYTE}}. It then drains execute-stage updates from a small FIFO onto
// the table write port, one per cycle, and counts updates lost to overflow.
//
// Optional feature macro: BP_UPDATE_BYPASS_EN
//   When defined, an update that arrives in RUN while the FIFO is empty and
//   the write port is idle is driven onto up_* combinationally in the same
//   cycle, and is not queued. When undefined, up_* are purely registered.
//
// Parameters
//   FIFO_DEPTH_L : log2 of the update FIFO depth
//   INIT_BYTE    : byte written to every lane during the init sweep
//
// Ports
//   clk                       : clock
//   reset                     : synchronous, active-high reset
//   execute_bpredictor_update : update request (at most one per cycle)
//   execute_bpredictor_meta   : [7:0] index, [15:8] counter byte, [19:16] be
//   up_index / up_data / up_be / up_wen : table write port
//   ctrl_busy                 : init sweep in progress
//   ctrl_full                 : FIFO full (stall hint for fetch)
//   ctrl_drop_count           : saturating count of dropped updates
// -----------------------------------------------------------------------------
`ifndef BP_META_WIDTH
`define BP_META_WIDTH 20
`endif

module soin_bpredictor_update_ctrl #(
  parameter int unsigned FIFO_DEPTH_L = 2,
  parameter logic [7:0]  INIT_BYTE    = 8'h55
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      execute_bpredictor_update,
  input  logic [`BP_META_WIDTH-1:0] execute_bpredictor_meta,
  output logic [7:0]                up_index,
  output logic [31:0]               up_data,
  output logic [3:0]                up_be,
  output logic                      up_wen,
  output logic                      ctrl_busy,
  output logic                      ctrl_full,
  output logic [7:0]                ctrl_drop_count
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_L;

  typedef logic [FIFO_DEPTH_L-1:0] ptr_t;
  typedef logic [FIFO_DEPTH_L:0]   cnt_t;
  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
  localparam cnt_t CNT_ONE = cnt_t'(1'b1);
  localparam ptr_t PTR_ONE = ptr_t'(1'b1);

  state_t      state_r;
  logic [7:0]  sw_idx_r;
  logic [19:0] fifo_mem_r [DEPTH];
  ptr_t        wr_ptr_r;
  ptr_t        rd_ptr_r;
  cnt_t        count_r;
  cnt_t        count_next_s;

  logic [7:0]  up_index_r;
  logic [31:0] up_data_r;
  logic [3:0]  up_be_r;
  logic        up_wen_r;
  logic        busy_r;
  logic        full_r;
  logic [7:0]  drop_r;

  logic [19:0] in_entry_s;
  logic [19:0] head_s;
  logic        in_run_s;
  logic        fifo_empty_s;
  logic        pop_s;
  logic        direct_s;
  logic        bypass_s;
  logic        push_s;
  logic        drop_s;

  // Entry layout is {index, byte, be}.
  assign in_entry_s   = {execute_bpredictor_meta[7:0],
                         execute_bpredictor_meta[15:8],
                         execute_bpredictor_meta[19:16]};
  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign in_run_s     = (state_r == ST_RUN);
  assign fifo_empty_s = (count_r == cnt_t'(1'b0));
  assign pop_s        = in_run_s && !fifo_empty_s;
  // An update meeting an empty FIFO in RUN goes straight to the write port.
  assign direct_s     = in_run_s && fifo_empty_s && execute_bpredictor_update;
`ifdef BP_UPDATE_BYPASS_EN
  // Only bypass when the registered port is idle, so nothing gets overwritten.
  assign bypass_s     = direct_s && !up_wen_r;
`else
  assign bypass_s     = 1'b0;
`endif
  // A full FIFO still accepts when its head leaves on the same edge.
  assign push_s       = execute_bpredictor_update && !direct_s &&
                        ((count_r != DEPTH_C) || pop_s);
  assign drop_s       = execute_bpredictor_update && !direct_s && !push_s;

  // Occupancy after the current edge.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO storage write; pointers guarantee stale contents are never read.
  always_ff @(posedge clk) begin
    if (push_s && !reset) begin
      fifo_mem_r[wr_ptr_r] <= in_entry_s;
    end
  end

  // Sweep/drain FSM, FIFO pointers, status flags and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_INIT;
      sw_idx_r   <= 8'h00;
      wr_ptr_r   <= ptr_t'(1'b0);
      rd_ptr_r   <= ptr_t'(1'b0);
      count_r    <= cnt_t'(1'b0);
      up_index_r <= 8'h00;
      up_data_r  <= 32'h0000_0000;
      up_be_r    <= 4'h0;
      up_wen_r   <= 1'b0;
      busy_r     <= 1'b1;
      full_r     <= 1'b0;
      drop_r     <= 8'h00;
    end else begin
      // busy lags the FSM so it falls the cycle after the last sweep write.
      busy_r  <= (state_r == ST_INIT);
      full_r  <= (count_next_s == DEPTH_C);
      count_r <= count_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (drop_s && (drop_r != 8'hFF)) begin
        drop_r <= drop_r + 8'h01;
      end
      case (state_r)
        ST_INIT: begin
          up_index_r <= sw_idx_r;
          up_data_r  <= {4{INIT_BYTE}};
          up_be_r    <= 4'hF;
          up_wen_r   <= 1'b1;
          sw_idx_r   <= sw_idx_r + 8'h01;
          if (sw_idx_r == 8'hFF) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (pop_s) begin
            up_index_r <= head_s[19:12];
            up_data_r  <= {4{head_s[11:4]}};
            up_be_r    <= head_s[3:0];
            up_wen_r   <= 1'b1;
          end else if (direct_s && !bypass_s) begin
            up_index_r <= in_entry_s[19:12];
            up_data_r  <= {4{in_entry_s[11:4]}};
            up_be_r    <= in_entry_s[3:0];
            up_wen_r   <= 1'b1;
          end else begin
            up_wen_r   <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_INIT;
          sw_idx_r <= 8'h00;
          up_wen_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef BP_UPDATE_BYPASS_EN
  // Write port: same-cycle bypass overrides the registered port when idle.
  always_comb begin
    if (bypass_s) begin
      up_index = in_entry_s[19:12];
      up_data  = {4{in_entry_s[11:4]}};
      up_be    = in_entry_s[3:0];
      up_wen   = 1'b1;
    end else begin
      up_index = up_index_r;
      up_data  = up_data_r;
      up_be    = up_be_r;
      up_wen   = up_wen_r;
    end
  end
`else
  assign up_index = up_index_r;
  assign up_data  = up_data_r;
  assign up_be    = up_be_r;
  assign up_wen   = up_wen_r;
`endif

  assign ctrl_busy       = busy_r;
  assign ctrl_full       = full_r;
  assign ctrl_drop_count = drop_r;

endmodule

// File: tb/tb_soin_bpredictor_update_ctrl.sv
`ifndef BP_META_WIDTH
`define BP_META_WIDTH 20
`endif

module tb_soin_bpredictor_update_ctrl;

  logic                      clk;
  logic                      reset;
  logic                      execute_bpredictor_update;
  logic [`BP_META_WIDTH-1:0] execute_bpredictor_meta;
  logic [7:0]                up_index;
  logic [31:0]               up_data;
  logic [3:0]                up_be;
  logic                      up_wen;
  logic                      ctrl_busy;
  logic                      ctrl_full;
  logic [7:0]                ctrl_drop_count;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of pending updates plus sweep progress.
  logic [19:0] q [$];
  bit          m_init;
  int          m_pos;
  logic        e_wen;
  logic [7:0]  e_idx;
  logic [31:0] e_data;
  logic [3:0]  e_be;
  logic        e_busy;
  logic        e_full;
  int          e_drop;

  soin_bpredictor_update_ctrl dut (
    .clk                       (clk),
    .reset                     (reset),
    .execute_bpredictor_update (execute_bpredictor_update),
    .execute_bpredictor_meta   (execute_bpredictor_meta),
    .up_index                  (up_index),
    .up_data                   (up_data),
    .up_be                     (up_be),
    .up_wen                    (up_wen),
    .ctrl_busy                 (ctrl_busy),
    .ctrl_full                 (ctrl_full),
    .ctrl_drop_count           (ctrl_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] mk_meta(input logic [7:0] idx, input logic [7:0] b,
                                          input logic [3:0] be);
    return {be, b, idx};
  endfunction

  function automatic logic [19:0] rnd_meta();
    logic [19:0] m;
    m = 20'($urandom);
    if (($urandom % 8) == 0) m[19:16] = 4'h0;
    return m;
  endfunction

  task automatic issue(input logic [19:0] m);
    e_wen  = 1'b1;
    e_idx  = m[7:0];
    e_data = {4{m[15:8]}};
    e_be   = m[19:16];
  endtask

  // One clock: drive inputs, advance the model at the edge, then compare.
  task automatic step(input logic rst, input logic upd, input logic [19:0] meta);
    reset = rst;
    execute_bpredictor_update = upd;
    execute_bpredictor_meta = meta;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_init = 1'b1; m_pos = 0;
      e_wen = 1'b0; e_idx = 8'h00; e_data = 32'h0; e_be = 4'h0;
      e_busy = 1'b1; e_drop = 0;
    end else begin
      e_busy = m_init;
      if (m_init) begin
        issue({4'hF, 8'h55, 8'(m_pos)});
        if (upd) begin
          if (q.size() < 4) q.push_back(meta);
          else if (e_drop < 255) e_drop++;
        end
        m_pos++;
        if (m_pos == 256) m_init = 1'b0;
      end else begin
        // In RUN a full queue always has its head leaving, so nothing drops.
        if (upd) q.push_back(meta);
        if (q.size() > 0) issue(q.pop_front());
        else e_wen = 1'b0;
      end
    end
    e_full = (q.size() == 4);
    #1;
    chk("wen", 32'(up_wen), 32'(e_wen));
    chk("busy", 32'(ctrl_busy), 32'(e_busy));
    chk("full", 32'(ctrl_full), 32'(e_full));
    chk("drop", 32'(ctrl_drop_count), 32'(e_drop));
    if (e_wen || rst) begin
      chk("index", 32'(up_index), 32'(e_idx));
      chk("data", up_data, e_data);
      chk("be", 32'(up_be), 32'(e_be));
    end
  endtask

  task automatic finish_sweep();
    while (m_init) step(1'b0, 1'b0, 20'h0);
  endtask

  initial begin
    logic [7:0] drop_before;
    reset = 1'b1;
    execute_bpredictor_update = 1'b0;
    execute_bpredictor_meta = '0;

    // Reset, then six back-to-back updates at the start of the sweep.
    repeat (3) step(1'b1, 1'b0, 20'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, rnd_meta());
    chk("drop_after6", 32'(ctrl_drop_count), 32'd2);
    chk("full_after6", 32'(ctrl_full), 32'd1);
    finish_sweep();
    chk("busy_after_sweep", 32'(ctrl_busy), 32'd1);
    repeat (6) step(1'b0, 1'b0, 20'h0);
    chk("busy_in_run", 32'(ctrl_busy), 32'd0);

    // Single update in RUN: visible on the next cycle.
    step(1'b0, 1'b1, mk_meta(8'h3C, 8'hA5, 4'b0100));
    chk("one_idx", 32'(up_index), 32'h3C);
    chk("one_data", up_data, 32'hA5A5A5A5);
    chk("one_be", 32'(up_be), 32'h4);
    chk("one_wen", 32'(up_wen), 32'd1);
    step(1'b0, 1'b0, 20'h0);

    // Fill during INIT, then push every cycle in RUN while full.
    step(1'b1, 1'b0, 20'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, rnd_meta());
    finish_sweep();
    drop_before = ctrl_drop_count;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, rnd_meta());
      chk("full_push_pop", 32'(ctrl_full), 32'd1);
      chk("drop_unchanged", 32'(ctrl_drop_count), 32'(drop_before));
    end
    repeat (6) step(1'b0, 1'b0, 20'h0);

    // Reset at sweep index 100 with two updates queued.
    step(1'b1, 1'b0, 20'h0);
    step(1'b0, 1'b1, rnd_meta());
    step(1'b0, 1'b1, rnd_meta());
    while (m_pos < 100) step(1'b0, 1'b0, 20'h0);
    step(1'b1, 1'b0, 20'h0);
    step(1'b0, 1'b0, 20'h0);
    chk("restart_idx", 32'(up_index), 32'h0);
    chk("restart_drop", 32'(ctrl_drop_count), 32'd0);
    finish_sweep();
    step(1'b0, 1'b0, 20'h0);
    chk("flushed_no_write", 32'(up_wen), 32'd0);

    // Randomized traffic in RUN, including zero byte-enables and bursts.
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 1'(($urandom % 4) != 0), rnd_meta());
    end
    repeat (6) step(1'b0, 1'b0, 20'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soin_bpredictor_update_ctrl.md
# soin_bpredictor_update_ctrl

Write-port controller for the bimodal predictor pattern table (BRAM_32_8, 256 × 32-bit, 4 byte lanes). It sits between the execute-stage update interface and the table write port. After reset it sweeps every table entry to a known counter value. After that it buffers execute-stage updates in a small FIFO and drains one update per cycle onto the table write port, tracking any updates lost to overflow.

## Interface
Parameters:
- FIFO_DEPTH_L, 2, log2 of update FIFO depth (default depth 4).
- INIT_BYTE, 8'h55, byte written to every lane during the init sweep (four 2-bit counters at 01, weakly not-taken).

Ports:
- clk  in  1  clock, the only clock.
- reset  in  1  synchronous, active-high.
- execute_bpredictor_update  in  1  update request, one per cycle maximum.
- execute_bpredictor_meta  in  `BP_META_WIDTH  meta field decoded as follows:
  - bits [7:0]: table index.
  - bits [15:8]: counter byte.
  - bits [19:16]: byte enable.
- up_index  out  8  table write address.
- up_data  out  32  table write data, {4{byte}}.
- up_be  out  4  table byte enable.
- up_wen  out  1  table write enable.
- ctrl_busy  out  1  init sweep in progress.
- ctrl_full  out  1  FIFO holds 2^FIFO_DEPTH_L entries; the fetch side must treat this as a stall hint.
- ctrl_drop_count  out  8  saturating count of updates dropped on overflow.

## Operation
- FSM states:
  - INIT: sweep pointer sw_idx starts at 0. Each cycle drives up_index = sw_idx, up_data = {4{INIT_BYTE}}, up_be = 4'hF, up_wen = 1, then increments sw_idx. When a write is issued with sw_idx == 8'hFF, the FSM moves to RUN.
  - RUN: if the FIFO is non-empty, pop the head and drive it on up_*, with up_wen = 1. Otherwise up_wen = 0.
- FIFO push occurs whenever execute_bpredictor_update = 1 and the entry is accepted. Pushes are accepted in both INIT and RUN.
- Acceptance rule: a push is accepted if the occupancy before the edge is below depth, or if a pop occurs in the same cycle. A push that is not accepted is dropped, and ctrl_drop_count increments, saturating at 8'hFF.
- FIFO storage per entry is {index[7:0], byte[7:0], be[3:0]}, 20 bits. Read and write pointers are FIFO_DEPTH_L bits wide and wrap modulo depth. Occupancy is FIFO_DEPTH_L+1 bits.
- Entries are drained strictly in FIFO order. Two entries to the same index are both written, in order; no coalescing.
- An update with be = 4'h0 is still queued and issued, as a write with no lanes enabled.

## Timing
- Output reset values: up_wen = 0, up_index = 0, up_data = 0, up_be = 0, ctrl_busy = 1, ctrl_full = 0, ctrl_drop_count = 0. The FIFO is emptied and the FSM is placed in INIT with sw_idx = 0.
- The first sweep write occurs in the first cycle after reset deasserts. The sweep takes exactly 256 cycles.
- ctrl_busy falls in the cycle after the write to index 8'hFF.
- up_* are registered outputs. An update accepted at edge N into an empty FIFO in RUN appears on up_* in cycle N+1, i.e. one cycle of latency. Sustained throughput is one update per cycle.
- ctrl_full is registered from the occupancy after the edge.
- Reset asserted mid-sweep or mid-drain restarts the sweep at 0, flushes the FIFO, and clears ctrl_drop_count in the same cycle.
- Updates arriving during INIT accumulate in the FIFO and drain from the first RUN cycle, 1 per cycle.

## Configuration
- BP_UPDATE_BYPASS_EN:
  - Defined: in RUN with an empty FIFO, an incoming update is driven combinationally onto up_* in the same cycle (zero latency) and is not pushed. All other cases behave as without the macro; up_* become combinational outputs.
  - Undefined: all updates pass through the FIFO, with one-cycle latency as specified above.

## Test plan
- Reset for 3 cycles, then release:
  - up_wen = 1 for exactly 256 consecutive cycles, with up_index running 0..255, up_data = 32'h55555555 and up_be = 4'hF.
  - ctrl_busy deasserts on the 257th cycle.
- In RUN, single update with meta index = 8'h3C, byte = 8'hA5, be = 4'b0100:
  - Without the macro: the next cycle shows up_index = 8'h3C, up_data = 32'hA5A5A5A5, up_be = 4'b0100, up_wen = 1.
  - With BP_UPDATE_BYPASS_EN: the same values appear in the same cycle.
- Six back-to-back updates during INIT (depth 4):
  - The first four are accepted, ctrl_full = 1, and ctrl_drop_count = 2.
  - After the sweep, the four entries drain in order in 4 consecutive cycles.
- FIFO full in RUN, with a push on the same cycle as a pop: the push is accepted, ctrl_drop_count is unchanged, and ctrl_full stays 1.
- Reset asserted at sweep index 100 with 2 entries queued: the sweep restarts at 0, the queued entries are never written, and ctrl_drop_count = 0.
